imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the byte-addressable instruction ROM. It accepts a framed byte stream over a valid/ready handshake and writes each instruction byte into instruction memory at consecutive byte addresses starting at 0. It verifies the frame length and checksum, and holds the core in reset while loading. It sits between the host/debug link and the instruction memory's write port, in parallel with the core's fetch read port.

## Interface
- N, 1024, instruction capacity in 32-bit words; memory holds 4*N bytes
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load frame; sampled in IDLE, DONE and ERR only
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  byte write strobe to instruction memory
- mem_addr  out  32  byte address of the write; bits above clog2(4N) always 0
- mem_wd  out  8  byte to write
- busy  out  1  load in progress; the core must be held in reset while high
- done  out  1  last frame loaded and checksum matched
- err  out  2  2'b01 length overflow, 2'b10 checksum mismatch, 2'b00 none

## Operation
- Frame format, in byte order:
  - 4-byte word count C, little-endian.
  - 4*C image bytes. Each word is sent LSB first, the same order as the hex image byte layout. Stream byte k is written to address k.
  - 1 checksum byte S. The frame is good when (sum of all image bytes + S) mod 256 == 0. Header bytes are excluded from the sum.
- States:
  - IDLE: start -> HDR.
  - HDR: accept 4 bytes into count register. After the 4th byte: C > N -> ERR with err=01; C == 0 -> CHK; otherwise -> DATA.
  - DATA: each accepted byte issues one memory write and is added to the 8-bit running sum. The byte counter counts 0..4C-1. The last byte -> CHK.
  - CHK: accept 1 byte. (sum + byte) mod 256 == 0 -> DONE; otherwise -> ERR with err=10.
  - DONE / ERR: outputs hold. start -> HDR, which clears done, err, the sum and the counter.
- Handshake:
  - A transfer occurs on a cycle with in_valid && in_ready.
  - in_ready = 1 in HDR, DATA and CHK, and 0 elsewhere.
  - in_ready depends on state only, never on in_valid.
  - in_valid gaps of any length are legal; no write is issued on a non-transfer cycle.
- busy = 1 in HDR, DATA and CHK.
- start is ignored while busy. Bytes offered outside HDR/DATA/CHK are not accepted.
- Sum and byte counter are modular: the sum is 8-bit wrap. The counter is clog2(4N)+1 bits, so C == N addresses byte 4N-1 without wrapping.
- ERR after a checksum failure leaves already-written bytes in memory. The loader does not roll them back; software reloads.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wd=0, busy=0, done=0, err=00. State = IDLE.
- rst mid-frame: next cycle all outputs are at reset values. The partial image stays in memory, and no further writes occur.
- Start latency: start sampled at edge t -> busy=1 and in_ready=1 from edge t onward (registered). The first byte can transfer in the cycle after t.
- Write latency: a DATA byte transferring in the cycle ending at edge c gives mem_we=1, mem_addr=k, mem_wd=byte for exactly the cycle after c. All three outputs are registered, and mem_we is a one-cycle pulse per byte.
- Throughput: one byte per cycle sustained, with no bubbles between HDR, DATA and CHK.
- Completion: the checksum byte transfers at edge c.
  - done or err is set at c.
  - busy and in_ready drop at c.
  - The last mem_we pulse precedes c by at least one cycle.
- Overflow: err=01 and busy=0 at the edge that accepts the 4th header byte. No mem_we is ever issued.

## Test plan
- Good 1-word frame: 01 00 00 00 93 00 50 00 1D, in_valid held high -> writes (0,93),(1,00),(2,50),(3,00) on 4 consecutive cycles; done=1, err=00, busy=0 one cycle after the 1D transfer.
- Bad checksum: same frame with last byte 1E -> the same 4 writes, then err=10, done=0.
- Overflow (N=1024): header 01 04 00 00 (C=1025) -> err=01 after the 4th byte, in_ready=0, zero mem_we pulses; the next offered byte is not accepted.
- Empty frame: 00 00 00 00 00 -> no writes, done=1 after 5 transfers.
- Backpressure/gaps: the good frame with in_valid alternating 1/0 -> identical write sequence, one write per transfer. start pulsed mid-DATA is ignored, and busy stays 1.
- Reset mid-DATA: rst for 1 cycle after 2 image bytes -> next cycle all outputs zero. Remaining bytes are not accepted, and no writes occur until a new start.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the byte-addressable instruction ROM. It accepts a
// framed byte stream over a valid/ready handshake:
//     4-byte little-endian word count C, 4*C image bytes, 1 checksum byte S.
// Each image byte is written to consecutive byte addresses starting at 0.
// The frame is good when (sum of image bytes + S) mod 256 == 0. The core
// must be held in reset while busy is high.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   start     in   begin a load frame (honoured in IDLE, DONE and ERR only)
//   in_valid  in   stream byte valid
//   in_data   in   stream byte [7:0]
//   in_ready  out  loader accepts a byte this cycle (HDR/DATA/CHK)
//   mem_we    out  one-cycle byte write strobe to instruction memory
//   mem_addr  out  byte address [31:0]; bits above clog2(4N) are always 0
//   mem_wd    out  byte to write [7:0]
//   busy      out  load in progress
//   done      out  last frame loaded with a matching checksum
//   err       out  2'b01 length overflow, 2'b10 checksum mismatch
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int N = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wd,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    localparam int AW = $clog2(4 * N);
    // One extra bit so that C == N reaches byte 4N-1 without wrapping.
    localparam int CW = AW + 1;
    localparam logic [CW-3:0] ONE_W = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [23:0]     r_hdr;        // upper three header bytes seen so far
    logic [1:0]      r_hdr_idx;
    logic [CW-1:0]   r_cnt;        // image byte index, 0..4C-1
    logic [CW-1:0]   r_last;       // 4C-1, latched after the header
    logic [7:0]      r_sum;
    logic [1:0]      r_err;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [7:0]      r_mem_wd;

    logic            w_xfer;
    logic [31:0]     w_hdr_c;
    logic            w_hdr_last;
    logic            w_ovf;
    logic            w_empty;
    logic [CW-3:0]   w_cm1;
    logic            w_data_last;
    logic [7:0]      w_sum_next;
    logic            w_start_ok;

    assign w_xfer      = in_valid && in_ready;
    // Little-endian shift: the first header byte ends up in bits [7:0].
    assign w_hdr_c     = {in_data, r_hdr};
    assign w_hdr_last  = (r_hdr_idx == 2'd3);
    assign w_ovf       = (w_hdr_c > 32'(N));
    assign w_empty     = (w_hdr_c == 32'd0);
    assign w_cm1       = w_hdr_c[CW-3:0] - ONE_W;
    assign w_data_last = (r_cnt == r_last);
    assign w_sum_next  = r_sum + in_data;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_HDR;
            end
            S_HDR: begin
                if (w_xfer && w_hdr_last) begin
                    if (w_ovf)        w_next = S_ERR;
                    else if (w_empty) w_next = S_CHK;
                    else              w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && w_data_last) w_next = S_CHK;
            end
            S_CHK: begin
                if (w_xfer) w_next = (w_sum_next == 8'd0) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start) w_next = S_HDR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; in_ready never looks at in_valid.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_HDR, S_DATA, S_CHK: busy = 1'b1;
            S_DONE:               done = 1'b1;
            default: ;
        endcase
        in_ready = busy;
    end

    // Header, counter, checksum and registered memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_idx  <= 2'd0;
            r_cnt      <= '0;
            r_sum      <= 8'd0;
            r_err      <= 2'b00;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= 8'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_ok) begin
                r_hdr_idx <= 2'd0;
                r_cnt     <= '0;
                r_sum     <= 8'd0;
                r_err     <= 2'b00;
            end
            case (r_state)
                S_HDR: begin
                    if (w_xfer) begin
                        r_hdr     <= w_hdr_c[31:8];
                        r_hdr_idx <= r_hdr_idx + 2'd1;
                        if (w_hdr_last) begin
                            r_last <= {w_cm1, 2'b11};
                            if (w_ovf) r_err <= 2'b01;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_cnt[AW-1:0];
                        r_mem_wd   <= in_data;
                        r_sum      <= w_sum_next;
                        r_cnt      <= r_cnt + CW'(1);
                    end
                end
                S_CHK: begin
                    if (w_xfer && (w_sum_next != 8'd0)) r_err <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_addr = {{(32 - AW){1'b0}}, r_mem_addr};
    assign mem_wd   = r_mem_wd;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wd;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    always #5 clk = ~clk;

    imem_loader #(.N(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        string            name;
        int               len;
        logic [15:0][7:0] b;
        bit               gaps;
        bit               mid_start;
        logic             exp_done;
        logic [1:0]       exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          when;
    } wr_t;

    wr_t  sbq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected write,
    // including the cycle in which it appears.
    always @(negedge clk) begin
        wr_t w;
        if (mem_we === 1'b1) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wd);
            end else begin
                w = sbq.pop_front();
                check("wr_addr", mem_addr, w.addr);
                check("wr_data", {24'd0, mem_wd}, {24'd0, w.data});
                check("wr_cycle", cyc, w.when);
            end
        end
    end

    function automatic vec_t mk(input string name, input int len, input logic [127:0] bytes_msb_first,
                                input bit gaps, input bit mid, input logic d, input logic [1:0] e);
        vec_t v;
        v.name = name;
        v.len = len;
        v.b = '0;
        for (int i = 0; i < len; i++) v.b[i] = bytes_msb_first[(len - 1 - i) * 8 +: 8];
        v.gaps = gaps;
        v.mid_start = mid;
        v.exp_done = d;
        v.exp_err = e;
        return v;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ready_after_start", {31'd0, in_ready}, 32'd1);
    endtask

    // Drives a frame from a negedge onward; returns at the negedge just after
    // the last byte transferred.
    task automatic send(input logic [7:0] fr[$], input bit gaps, input bit mid);
        int  i = 0;
        int  guard = 0;
        int  limit = 3 * fr.size() + 20;
        bit  ph = 1'b0;
        bit  did_mid = 1'b0;
        bit  chk_busy = 1'b0;
        while (i < fr.size() && guard < limit) begin
            if (chk_busy) begin
                check("busy_after_mid_start", {31'd0, busy}, 32'd1);
                chk_busy = 1'b0;
            end
            start = 1'b0;
            if (gaps && ph) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data = fr[i];
            end
            ph = ~ph;
            if (mid && !did_mid && i == 6) begin
                start = 1'b1;
                in_valid = 1'b0;
                did_mid = 1'b1;
                chk_busy = 1'b1;
            end
            if (in_valid && in_ready) begin
                if (i >= 4 && i < fr.size() - 1)
                    sbq.push_back('{addr: 32'(i - 4), data: fr[i], when: cyc + 1});
                i++;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (i < fr.size()) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_timeout: got %0d bytes accepted, required %0d", i, fr.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
        check({tag, "_mem_addr"}, mem_addr,          32'd0);
        check({tag, "_mem_wd"},   {24'd0, mem_wd},   32'd0);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_err"},      {30'd0, err},      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish by 2000000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fr[$];

        vecs[0] = mk("good_1w",       9, 128'h01000000_93005000_1D,             0, 0, 1'b1, 2'b00);
        vecs[1] = mk("bad_cksum_1w",  9, 128'h01000000_93005000_1E,             0, 0, 1'b0, 2'b10);
        vecs[2] = mk("good_gaps_mid", 9, 128'h01000000_93005000_1D,             1, 1, 1'b1, 2'b00);
        vecs[3] = mk("empty",         5, 128'h00000000_00,                      0, 0, 1'b1, 2'b00);
        vecs[4] = mk("good_2w_gaps", 13, 128'h02000000_11223344_55667788_9C,    1, 0, 1'b1, 2'b00);
        vecs[5] = mk("bad_2w",       13, 128'h02000000_11223344_55667788_9D,    0, 0, 1'b0, 2'b10);

        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            fr.delete();
            for (int i = 0; i < vecs[v].len; i++) fr.push_back(vecs[v].b[i]);
            do_start();
            send(fr, vecs[v].gaps, vecs[v].mid_start);
            check({vecs[v].name, "_done"},  {31'd0, done},     {31'd0, vecs[v].exp_done});
            check({vecs[v].name, "_err"},   {30'd0, err},      {30'd0, vecs[v].exp_err});
            check({vecs[v].name, "_busy"},  {31'd0, busy},     32'd0);
            check({vecs[v].name, "_ready"}, {31'd0, in_ready}, 32'd0);
            check({vecs[v].name, "_sb_empty"}, 32'(sbq.size()), 32'd0);
        end

        // Overflow: C = 1025, no writes, nothing accepted afterwards.
        fr.delete();
        fr = '{8'h01, 8'h04, 8'h00, 8'h00};
        do_start();
        send(fr, 0, 0);
        check("ovf_err",   {30'd0, err},      32'd1);
        check("ovf_busy",  {31'd0, busy},     32'd0);
        check("ovf_ready", {31'd0, in_ready}, 32'd0);
        check("ovf_done",  {31'd0, done},     32'd0);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data = 8'hAA;
            @(negedge clk);
            check("ovf_ready_after", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("ovf_err_hold", {30'd0, err}, 32'd1);

        // Reset after two image bytes of the good frame.
        do_start();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = vecs[0].b[i];
            if (i >= 4) sbq.push_back('{addr: 32'(i - 4), data: vecs[0].b[i], when: cyc + 1});
            @(negedge clk);
        end
        rst = 1'b1;
        in_data = vecs[0].b[6];
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        for (int i = 7; i < 9; i++) begin
            in_data = vecs[0].b[i];
            @(negedge clk);
            check("midrst_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("midrst_sb_empty", 32'(sbq.size()), 32'd0);

        // Full capacity C == N: 4096 bytes of i mod 256 sum to 0 mod 256.
        fr.delete();
        fr = '{8'h00, 8'h04, 8'h00, 8'h00};
        for (int i = 0; i < 4096; i++) fr.push_back(8'(i));
        fr.push_back(8'h00);
        do_start();
        send(fr, 0, 0);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_err",  {30'd0, err},  32'd0);
        check("full_sb_empty", 32'(sbq.size()), 32'd0);

        // Restart from DONE runs a good frame again cleanly.
        fr.delete();
        for (int i = 0; i < vecs[0].len; i++) fr.push_back(vecs[0].b[i]);
        do_start();
        send(fr, 0, 0);
        check("restart_done", {31'd0, done}, 32'd1);
        check("restart_err",  {30'd0, err},  32'd0);
        repeat (2) @(negedge clk);
        check("final_sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
